// File: rtl/ctrl_sequencer_if.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer_if
//
// Bundles the control sequencer's connection to the LegV8 datapath: the
// instruction word and the two status inputs coming from the datapath, and
// every control field the sequencer drives back into it.
//
// Signals
//   instr       32      instruction word from instruction memory
//   alu_zero    1       combinational ALU zero flag for current FS/operands
//   mem_ready   1       data memory has completed the pending access
//   ir_load     1       load instruction register
//   da, sa, sb  5 each  register file destination / source A / source B
//   fs          5       ALU function select
//   ps          2       PC select: 00 hold, 01 PC+4, 10 PC+k, 11 PC<=reg[SA]
//   k           DATA_W  immediate / offset constant
//   b_sel       1       ALU B input: 0 reg[SB], 1 k
//   reg_write   1       register file write enable
//   mem_read    1       data memory read strobe
//   mem_write   1       data memory write strobe
//   status_load 1       load NZCV status register
//   state       2       00 FETCH, 01 EXEC, 10 MEM, 11 HALT
//   illegal     1       sticky undefined-opcode flag
//
// Modports
//   master  the sequencer (drives control fields)
//   slave   the datapath / test environment (drives instr and status)
// ---------------------------------------------------------------------------
interface ctrl_sequencer_if #(
    parameter int DATA_W = 64
);
    logic [31:0]       instr;
    logic              alu_zero;
    logic              mem_ready;

    logic              ir_load;
    logic [4:0]        da;
    logic [4:0]        sa;
    logic [4:0]        sb;
    logic [4:0]        fs;
    logic [1:0]        ps;
    logic [DATA_W-1:0] k;
    logic              b_sel;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              status_load;
    logic [1:0]        state;
    logic              illegal;

    modport master (
        input  instr, alu_zero, mem_ready,
        output ir_load, da, sa, sb, fs, ps, k, b_sel,
               reg_write, mem_read, mem_write, status_load, state, illegal
    );

    modport slave (
        output instr, alu_zero, mem_ready,
        input  ir_load, da, sa, sb, fs, ps, k, b_sel,
               reg_write, mem_read, mem_write, status_load, state, illegal
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
//
// Multi-cycle control sequencer for the LegV8 64-bit datapath. It latches the
// fetched instruction, decodes it and drives the datapath control fields one
// state at a time, stalling in MEM until data memory reports completion.
// An undefined opcode parks the sequencer in HALT with a sticky flag until
// reset.
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   asynchronous, active-low reset
//   bus     ctrl_sequencer_if.master: instr/alu_zero/mem_ready in,
//           all datapath control fields plus state/illegal out
//
// Sequencing
//   FETCH -> EXEC -> FETCH              ALU ops and branches (2 cycles)
//   FETCH -> EXEC -> MEM (N waits) -> FETCH   LDUR/STUR (3+N cycles)
//   EXEC with undefined opcode -> HALT (left only through reset)
//
// Outputs are combinational from the state register, the instruction
// register and the two status inputs; only state, IR and the illegal flag
// are stored.
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
    parameter int         DATA_W   = 64,
    parameter logic [4:0] FS_ADD   = 5'b01000,
    parameter logic [4:0] FS_SUB   = 5'b01001,
    parameter logic [4:0] FS_AND   = 5'b00000,
    parameter logic [4:0] FS_ORR   = 5'b00100,
    parameter logic [4:0] FS_PASSB = 5'b11100
) (
    input  logic             clock,
    input  logic             reset,
    ctrl_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        MEM   = 2'b10,
        HALT  = 2'b11
    } state_t;

    // Instruction classes; each class shares one EXEC/MEM behaviour.
    typedef enum logic [2:0] {
        OP_ALU  = 3'd0,   // register or immediate ALU op, writes Rd
        OP_LDUR = 3'd1,
        OP_STUR = 3'd2,
        OP_B    = 3'd3,
        OP_CB   = 3'd4,   // CBZ / CBNZ
        OP_BR   = 3'd5,
        OP_ILL  = 3'd6
    } op_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic [31:0] ir_reg;
    logic        illegal_reg;
    logic        illegal_set;

    // -----------------------------------------------------------------------
    // Instruction fields
    // -----------------------------------------------------------------------
    logic [10:0] opcode;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;

    assign opcode = ir_reg[31:21];
    assign rd     = ir_reg[4:0];
    assign rn     = ir_reg[9:5];
    assign rm     = ir_reg[20:16];

    // Immediates, all extended to the datapath width. For the branch forms
    // the word-offset shift is folded into the concatenation: the two bits
    // pushed out at the top are copies of the sign, so dropping them is the
    // same as extending first and shifting afterwards.
    logic [DATA_W-1:0] imm_alu;   // ADDI/SUBI: zero-extended IR[21:10]
    logic [DATA_W-1:0] imm_dt;    // LDUR/STUR: sign-extended IR[20:12]
    logic [DATA_W-1:0] imm_b;     // B: sext(IR[25:0]) << 2
    logic [DATA_W-1:0] imm_cb;    // CBZ/CBNZ: sext(IR[23:5]) << 2

    assign imm_alu = {{(DATA_W-12){1'b0}}, ir_reg[21:10]};
    assign imm_dt  = {{(DATA_W-9){ir_reg[20]}}, ir_reg[20:12]};
    assign imm_b   = {{(DATA_W-28){ir_reg[25]}}, ir_reg[25:0], 2'b00};
    assign imm_cb  = {{(DATA_W-21){ir_reg[23]}}, ir_reg[23:5], 2'b00};

    // -----------------------------------------------------------------------
    // Decoder: turns the latched opcode into an instruction class plus the
    // datapath fields that class needs. Fields a class does not use stay 0.
    // -----------------------------------------------------------------------
    op_t               dec_op;
    logic [4:0]        dec_da;
    logic [4:0]        dec_sa;
    logic [4:0]        dec_sb;
    logic [4:0]        dec_fs;
    logic [DATA_W-1:0] dec_k;
    logic              dec_b_sel;
    logic              dec_status;
    logic              dec_cbnz;

    always_comb begin
        dec_op     = OP_ILL;
        dec_da     = 5'd0;
        dec_sa     = 5'd0;
        dec_sb     = 5'd0;
        dec_fs     = 5'd0;
        dec_k      = '0;
        dec_b_sel  = 1'b0;
        dec_status = 1'b0;
        dec_cbnz   = 1'b0;

        casez (opcode)
            11'b10001011000: begin   // ADD
                dec_op = OP_ALU; dec_fs = FS_ADD;
                dec_da = rd; dec_sa = rn; dec_sb = rm;
            end
            11'b11001011000: begin   // SUB
                dec_op = OP_ALU; dec_fs = FS_SUB;
                dec_da = rd; dec_sa = rn; dec_sb = rm;
            end
            11'b10001010000: begin   // AND
                dec_op = OP_ALU; dec_fs = FS_AND;
                dec_da = rd; dec_sa = rn; dec_sb = rm;
            end
            11'b10101010000: begin   // ORR
                dec_op = OP_ALU; dec_fs = FS_ORR;
                dec_da = rd; dec_sa = rn; dec_sb = rm;
            end
            11'b10101011000: begin   // ADDS
                dec_op = OP_ALU; dec_fs = FS_ADD; dec_status = 1'b1;
                dec_da = rd; dec_sa = rn; dec_sb = rm;
            end
            11'b11101011000: begin   // SUBS
                dec_op = OP_ALU; dec_fs = FS_SUB; dec_status = 1'b1;
                dec_da = rd; dec_sa = rn; dec_sb = rm;
            end
            11'b1001000100?: begin   // ADDI (opcode LSB is immediate bit 11)
                dec_op = OP_ALU; dec_fs = FS_ADD;
                dec_da = rd; dec_sa = rn;
                dec_k = imm_alu; dec_b_sel = 1'b1;
            end
            11'b1101000100?: begin   // SUBI
                dec_op = OP_ALU; dec_fs = FS_SUB;
                dec_da = rd; dec_sa = rn;
                dec_k = imm_alu; dec_b_sel = 1'b1;
            end
            11'b11111000010: begin   // LDUR: address = reg[Rn] + offset
                dec_op = OP_LDUR; dec_fs = FS_ADD;
                dec_da = rd; dec_sa = rn;
                dec_k = imm_dt; dec_b_sel = 1'b1;
            end
            11'b11111000000: begin   // STUR: Rt is routed out on port B
                dec_op = OP_STUR; dec_fs = FS_ADD;
                dec_sa = rn; dec_sb = rd;
                dec_k = imm_dt; dec_b_sel = 1'b1;
            end
            11'b000101?????: begin   // B
                dec_op = OP_B;
                dec_k  = imm_b;
            end
            11'b1011010????: begin   // CBZ / CBNZ: ALU passes reg[Rt] to test zero
                dec_op   = OP_CB; dec_fs = FS_PASSB;
                dec_sb   = rd;
                dec_k    = imm_cb;
                dec_cbnz = opcode[3];
            end
            11'b11010110000: begin   // BR
                dec_op = OP_BR;
                dec_sa = rn;
            end
            default: begin
                dec_op = OP_ILL;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    logic              load_ir;
    logic [4:0]        da;
    logic [4:0]        sa;
    logic [4:0]        sb;
    logic [4:0]        fs;
    logic [1:0]        ps;
    logic [DATA_W-1:0] k;
    logic              b_sel;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              status_load;
    logic              cb_taken;

    // CBZ branches on zero, CBNZ on non-zero.
    assign cb_taken = dec_cbnz ? ~bus.alu_zero : bus.alu_zero;

    always_comb begin
        state_next  = state_reg;
        load_ir     = 1'b0;
        da          = 5'd0;
        sa          = 5'd0;
        sb          = 5'd0;
        fs          = 5'd0;
        ps          = 2'b00;
        k           = '0;
        b_sel       = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        status_load = 1'b0;
        illegal_set = 1'b0;

        case (state_reg)
            FETCH: begin
                load_ir    = 1'b1;
                state_next = EXEC;
            end

            EXEC: begin
                if (dec_op == OP_ILL) begin
                    // Nothing is driven for an undefined opcode.
                    illegal_set = 1'b1;
                    state_next  = HALT;
                end else begin
                    da    = dec_da;
                    sa    = dec_sa;
                    sb    = dec_sb;
                    fs    = dec_fs;
                    k     = dec_k;
                    b_sel = dec_b_sel;
                    state_next = FETCH;
                    case (dec_op)
                        OP_ALU: begin
                            reg_write   = 1'b1;
                            status_load = dec_status;
                            ps          = 2'b01;
                        end
                        OP_LDUR: begin
                            mem_read   = 1'b1;
                            state_next = MEM;
                        end
                        OP_STUR: begin
                            mem_write  = 1'b1;
                            state_next = MEM;
                        end
                        OP_B:    ps = 2'b10;
                        OP_CB:   ps = cb_taken ? 2'b10 : 2'b01;
                        OP_BR:   ps = 2'b11;
                        default: ps = 2'b00;
                    endcase
                end
            end

            MEM: begin
                // Address fields and strobe stay up for the whole access;
                // the load result is written in the same cycle memory
                // reports ready, and only then does the PC advance.
                da        = dec_da;
                sa        = dec_sa;
                sb        = dec_sb;
                fs        = dec_fs;
                k         = dec_k;
                b_sel     = dec_b_sel;
                mem_read  = (dec_op == OP_LDUR);
                mem_write = (dec_op == OP_STUR);
                if (bus.mem_ready) begin
                    ps         = 2'b01;
                    reg_write  = (dec_op == OP_LDUR);
                    state_next = FETCH;
                end
            end

            default: begin
                // HALT: everything quiet, stay put until reset.
                state_next = HALT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, instruction and sticky-flag registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= FETCH;
            ir_reg      <= 32'd0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_ir) begin
                ir_reg <= bus.instr;
            end
            if (illegal_set) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. The IR load enable is masked while reset is held so that the
    // datapath sees every enable low during reset even though the state
    // register already reads FETCH.
    // -----------------------------------------------------------------------
    assign bus.ir_load     = load_ir & reset;
    assign bus.da          = da;
    assign bus.sa          = sa;
    assign bus.sb          = sb;
    assign bus.fs          = fs;
    assign bus.ps          = ps;
    assign bus.k           = k;
    assign bus.b_sel       = b_sel;
    assign bus.reg_write   = reg_write;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.status_load = status_load;
    assign bus.state       = state_reg;
    assign bus.illegal     = illegal_reg;

endmodule
